regfile_access_ctrl: RTL and testbench

Initiator-side controller for the 16 x 32-bit dual-port register file. It accepts operand-fetch requests from decode and writebacks from execute, and drives both register-file ports. It tracks pending destinations in a busy scoreboard, bypasses same-cycle writeback data, and splits a fetch over two cycles when port 1 is taken by a writeback. It sits between decode/issue and the register file, and presents fetched operands to execute over a valid/ready handshake.

---
 rtl/regfile_access_ctrl_pkg.sv | 14 +
 rtl/regfile_access_ctrl_scoreboard.sv | 42 ++++
 rtl/regfile_access_ctrl.sv | 126 ++++++++++++
 tb/tb_regfile_access_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_access_ctrl_pkg.sv
// Shared configuration and FSM encoding for the register-file access controller.
package regfile_access_ctrl_pkg;

  localparam int WORD_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int AW       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD1  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_access_ctrl_scoreboard.sv
// Busy scoreboard for pending destination registers; set beats clear on the same index.
module regfile_access_ctrl_scoreboard
  import regfile_access_ctrl_pkg::*;
#(
  parameter int NUM_REGS_P = NUM_REGS,
  parameter int AW_P       = AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [AW_P-1:0]       set_idx,
  input  logic                  clr_en,
  input  logic [AW_P-1:0]       clr_idx,
  output logic [NUM_REGS_P-1:0] busy,
  output logic [NUM_REGS_P-1:0] eff,
  output logic                  wb_err
);

  logic [NUM_REGS_P-1:0] one_hot;
  logic [NUM_REGS_P-1:0] set_mask;
  logic [NUM_REGS_P-1:0] clr_mask;

  always_comb begin
    one_hot  = '0;
    one_hot[0] = 1'b1;
    set_mask = set_en ? (one_hot << set_idx) : '0;
    clr_mask = clr_en ? (one_hot << clr_idx) : '0;
    // A register freed by this cycle's writeback no longer blocks issue.
    eff      = busy & ~clr_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= '0;
      wb_err <= 1'b0;
    end else begin
      busy   <= (busy & ~clr_mask) | set_mask;
      wb_err <= clr_en && !busy[clr_idx];
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Operand-fetch controller: hazard check, port-1 arbitration with writebacks, bypass
// and a valid/ready operand output to execute.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int WORD_W_P   = WORD_W,
  parameter int NUM_REGS_P = NUM_REGS,
  parameter int AW_P       = AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [AW_P-1:0]       iss_rs0,
  input  logic [AW_P-1:0]       iss_rs1,
  input  logic [AW_P-1:0]       iss_rd,
  input  logic                  iss_rd_en,
  input  logic                  wb_valid,
  input  logic [AW_P-1:0]       wb_rd,
  input  logic [WORD_W_P-1:0]   wb_data,
  output logic                  wb_err,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [WORD_W_P-1:0]   op0,
  output logic [WORD_W_P-1:0]   op1,
  output logic [AW_P-1:0]       rf_addr0,
  output logic [AW_P-1:0]       rf_addr1,
  output logic [WORD_W_P-1:0]   rf_din0,
  output logic [WORD_W_P-1:0]   rf_din1,
  output logic                  rf_we0,
  output logic                  rf_we1,
  input  logic [WORD_W_P-1:0]   rf_dout0,
  input  logic [WORD_W_P-1:0]   rf_dout1,
  output logic [1:0]            dbg_state,
  output logic [NUM_REGS_P-1:0] dbg_busy
);

  // Handshakes: a fetch transfers on a cycle with iss_valid && iss_ready; operands
  // transfer on a cycle with op_valid && op_ready, and op0/op1 hold until then.

  state_t                state, state_nxt;
  logic [NUM_REGS_P-1:0] busy, eff;
  logic                  haz_ok, can_issue, accept, port1_wb;
  logic [WORD_W_P-1:0]   rd0_val;
  logic [WORD_W_P-1:0]   op0_q, op1_q;
  logic [AW_P-1:0]       rs1_q;

  regfile_access_ctrl_scoreboard #(
    .NUM_REGS_P (NUM_REGS_P),
    .AW_P       (AW_P)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (accept && iss_rd_en),
    .set_idx (iss_rd),
    .clr_en  (wb_valid),
    .clr_idx (wb_rd),
    .busy    (busy),
    .eff     (eff),
    .wb_err  (wb_err)
  );

  always_comb begin
    state_nxt = state;
    haz_ok    = !eff[iss_rs0] && !eff[iss_rs1] && (!iss_rd_en || !eff[iss_rd]);
    can_issue = (state == ST_IDLE) || ((state == ST_OUT) && op_ready);
    iss_ready = !rst && can_issue && haz_ok;
    accept    = iss_valid && iss_ready;
    port1_wb  = wb_valid && !rst;

    rf_we0    = 1'b0;
    rf_din0   = '0;
    rf_we1    = port1_wb;
    rf_din1   = port1_wb ? wb_data : '0;
    rf_addr1  = '0;
    rf_addr0  = '0;
    if (port1_wb)
      rf_addr1 = wb_rd;
    else if (accept)
      rf_addr1 = iss_rs1;
    if (accept)
      rf_addr0 = iss_rs0;
    else if (state == ST_RD1)
      rf_addr0 = rs1_q;

    // Port 0 read of the register being written this cycle returns the new value.
    rd0_val = (port1_wb && (wb_rd == rf_addr0)) ? wb_data : rf_dout0;

    case (state)
      ST_IDLE: if (accept) state_nxt = wb_valid ? ST_RD1 : ST_OUT;
      ST_RD1:  state_nxt = ST_OUT;
      ST_OUT: begin
        if (op_ready) begin
          if (accept) state_nxt = wb_valid ? ST_RD1 : ST_OUT;
          else        state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      op0_q <= '0;
      op1_q <= '0;
      rs1_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op0_q <= rd0_val;
        if (wb_valid) rs1_q <= iss_rs1;
        else          op1_q <= rf_dout1;
      end else if (state == ST_RD1) begin
        op1_q <= rd0_val;
      end
    end
  end

  assign op_valid  = (state == ST_OUT);
  assign op0       = op0_q;
  assign op1       = op1_q;
  assign dbg_state = state;
  assign dbg_busy  = busy;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural 16 x 32 register file.
module tb_regfile_access_ctrl;
  import regfile_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_ready, iss_rd_en;
  logic [3:0]  iss_rs0, iss_rs1, iss_rd;
  logic        wb_valid, wb_err;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        op_valid, op_ready;
  logic [31:0] op0, op1;
  logic [3:0]  rf_addr0, rf_addr1;
  logic [31:0] rf_din0, rf_din1, rf_dout0, rf_dout1;
  logic        rf_we0, rf_we1;
  logic [1:0]  dbg_state;
  logic [15:0] dbg_busy;

  logic [31:0] mem [16];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  regfile_access_ctrl dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs0(iss_rs0), .iss_rs1(iss_rs1), .iss_rd(iss_rd), .iss_rd_en(iss_rd_en),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err),
    .op_valid(op_valid), .op_ready(op_ready), .op0(op0), .op1(op1),
    .rf_addr0(rf_addr0), .rf_addr1(rf_addr1), .rf_din0(rf_din0), .rf_din1(rf_din1),
    .rf_we0(rf_we0), .rf_we1(rf_we1), .rf_dout0(rf_dout0), .rf_dout1(rf_dout1),
    .dbg_state(dbg_state), .dbg_busy(dbg_busy)
  );

  // Register file: reset preloads Rn = 0xnn, port 1 writes at the clock edge.
  assign rf_dout0 = mem[rf_addr0];
  assign rf_dout1 = mem[rf_addr1];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= {24'h0, 4'(i), 4'(i)};
    end else if (rf_we1) begin
      mem[rf_addr1] <= rf_din1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [3:0] r0, input logic [3:0] r1,
                       input logic [3:0] rd, input logic rd_en);
    iss_valid = v; iss_rs0 = r0; iss_rs1 = r1; iss_rd = rd; iss_rd_en = rd_en;
  endtask

  task automatic wb(input logic v, input logic [3:0] rd, input logic [31:0] d);
    wb_valid = v; wb_rd = rd; wb_data = d;
  endtask

  initial begin
    rst = 1'b1; op_ready = 1'b0;
    issue(0, 0, 0, 0, 0);
    wb(0, 0, 0);
    tick; tick;

    // Reset state
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op0", op0, 0);
    chk("rst_op1", op1, 0);
    chk("rst_iss_ready", iss_ready, 0);
    chk("rst_we", {rf_we0, rf_we1}, 0);
    chk("rst_addr", {rf_addr0, rf_addr1}, 0);
    chk("rst_din", rf_din0 | rf_din1, 0);
    chk("rst_busy", dbg_busy, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_wb_err", wb_err, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_iss_ready", iss_ready, 1);

    // Basic fetch rs0=1 rs1=2 rd=3
    issue(1, 1, 2, 3, 1);
    #1;
    chk("t1_iss_ready", iss_ready, 1);
    chk("t1_rf_addr0", rf_addr0, 1);
    chk("t1_rf_addr1", rf_addr1, 2);
    tick;
    issue(0, 0, 0, 0, 0);
    chk("t1_op_valid", op_valid, 1);
    chk("t1_op0", op0, 32'h11);
    chk("t1_op1", op1, 32'h22);
    chk("t1_busy", dbg_busy, 16'h0008);
    tick;
    chk("t1_hold_valid", op_valid, 1);
    chk("t1_hold_op0", op0, 32'h11);
    op_ready = 1'b1;
    tick;
    chk("t1_idle", dbg_state, ST_IDLE);
    chk("t1_op_valid_drop", op_valid, 0);

    // Busy source, freed by same-cycle writeback with bypass
    op_ready = 1'b0;
    issue(1, 3, 0, 0, 0);
    #1;
    chk("t2_stall", iss_ready, 0);
    tick;
    chk("t2_still_idle", dbg_state, ST_IDLE);
    wb(1, 3, 32'hABCD);
    #1;
    chk("t2_unblock", iss_ready, 1);
    chk("t2_we1", rf_we1, 1);
    chk("t2_addr1", rf_addr1, 3);
    chk("t2_din1", rf_din1, 32'hABCD);
    chk("t2_we0", rf_we0, 0);
    tick;
    issue(0, 0, 0, 0, 0);
    wb(0, 0, 0);
    chk("t2_rd1", dbg_state, ST_RD1);
    chk("t2_busy_clr", dbg_busy, 0);
    chk("t2_wb_err", wb_err, 0);
    #1;
    chk("t2_rd1_addr0", rf_addr0, 0);
    tick;
    chk("t2_op_valid", op_valid, 1);
    chk("t2_op0_bypass", op0, 32'hABCD);
    chk("t2_op1", op1, 32'h00);
    op_ready = 1'b1;
    tick;

    // Port conflict: writeback R5 while fetching rs0=4 rs1=5
    issue(1, 4, 5, 10, 1);
    wb(1, 5, 32'h5A5A);
    #1;
    chk("t3_iss_ready", iss_ready, 1);
    chk("t3_addr0", rf_addr0, 4);
    chk("t3_addr1_wb", rf_addr1, 5);
    chk("t3_we1_first", rf_we1, 1);
    tick;
    issue(0, 0, 0, 0, 0);
    wb(0, 0, 0);
    chk("t3_rd1_valid", op_valid, 0);
    chk("t3_wb_err", wb_err, 1);
    chk("t3_busy", dbg_busy, 16'h0400);
    #1;
    chk("t3_we1_second", rf_we1, 0);
    chk("t3_rd1_addr0", rf_addr0, 5);
    chk("t3_rd1_ready", iss_ready, 0);
    tick;
    chk("t3_op_valid", op_valid, 1);
    chk("t3_op0", op0, 32'h44);
    chk("t3_op1", op1, 32'h5A5A);
    chk("t3_wb_err_end", wb_err, 0);

    // Back-to-back with op_ready held high
    issue(1, 1, 2, 0, 0);
    #1;
    chk("t4_a_ready", iss_ready, 1);
    tick;
    chk("t4_a_valid", op_valid, 1);
    chk("t4_a_op", {op0[15:0], op1[15:0]}, 32'h0011_0022);
    issue(1, 4, 3, 0, 0);
    #1;
    chk("t4_b_ready", iss_ready, 1);
    tick;
    chk("t4_b_valid", op_valid, 1);
    chk("t4_b_op0", op0, 32'h44);
    chk("t4_b_op1", op1, 32'hABCD);
    issue(1, 5, 0, 0, 0);
    tick;
    chk("t4_c_valid", op_valid, 1);
    chk("t4_c_op0", op0, 32'h5A5A);
    chk("t4_c_op1", op1, 32'h0);
    issue(0, 0, 0, 0, 0);
    tick;
    chk("t4_idle", dbg_state, ST_IDLE);

    // WAW on R6, same-cycle clear+set, writeback to idle R7
    issue(1, 0, 0, 6, 1);
    tick;
    chk("t5_busy6", dbg_busy, 16'h0440);
    #1;
    chk("t5_waw_stall_out", iss_ready, 0);
    tick;
    chk("t5_back_idle", dbg_state, ST_IDLE);
    chk("t5_waw_stall_idle", iss_ready, 0);
    wb(1, 6, 32'h66);
    #1;
    chk("t5_waw_unblock", iss_ready, 1);
    tick;
    issue(0, 0, 0, 0, 0);
    wb(0, 0, 0);
    chk("t5_set_wins", dbg_busy, 16'h0440);
    chk("t5_no_err", wb_err, 0);
    chk("t5_rd1", dbg_state, ST_RD1);
    tick;
    chk("t5_out", op_valid, 1);
    tick;
    wb(1, 7, 32'h77);
    tick;
    wb(0, 0, 0);
    chk("t5_wb_err_pulse", wb_err, 1);
    tick;
    chk("t5_wb_err_clear", wb_err, 0);

    // Reset in RD1
    issue(1, 1, 2, 11, 1);
    wb(1, 6, 32'h60);
    tick;
    issue(0, 0, 0, 0, 0);
    wb(0, 0, 0);
    chk("t6_rd1", dbg_state, ST_RD1);
    chk("t6_busy", dbg_busy, 16'h0C00);
    rst = 1'b1;
    #1;
    chk("t6_rst_state", dbg_state, ST_IDLE);
    chk("t6_rst_valid", op_valid, 0);
    chk("t6_rst_busy", dbg_busy, 0);
    chk("t6_rst_op0", op0, 0);
    tick;
    rst = 1'b0;
    tick;
    chk("t6_after_we", {rf_we0, rf_we1}, 0);
    chk("t6_after_valid", op_valid, 0);
    chk("t6_after_state", dbg_state, ST_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
